// File: rtl/oh_arbiter_rr_if.sv
// Requester/arbiter handshake bundle for oh_arbiter_rr.
// The arbiter uses the slave modport; the requester side uses master.
interface oh_arbiter_rr_if #(
  parameter int N  = 4,
  parameter int NW = $clog2(N)
);
  logic [N-1:0]  requests;
  logic [N-1:0]  last;
  logic          ready;
  logic [N-1:0]  grants;
  logic [NW-1:0] grant_id;
  logic          busy;
  logic          timeout;

  modport master (
    output requests, last, ready,
    input  grants, grant_id, busy, timeout
  );

  modport slave (
    input  requests, last, ready,
    output grants, grant_id, busy, timeout
  );
endinterface

// File: rtl/oh_arbiter_rr.sv
// Registered round-robin arbiter with burst locking and a one-cycle IDLE bubble between grants.
// Define OH_ARB_TIMEOUT_EN to add a stall counter that force-releases a grant after TIMEOUT stall cycles.
module oh_arbiter_rr #(
  parameter int N       = 4,
  parameter int NW      = $clog2(N),
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  oh_arbiter_rr_if.slave bus
);

  localparam logic [0:0]  IDLE  = 1'b0;
  localparam logic [0:0]  BUSY  = 1'b1;
  localparam logic [NW:0] N_EXT = (NW+1)'(N);

  if (N < 2 || N > 32 || TIMEOUT < 2) begin : g_param_check
    $error("oh_arbiter_rr: N must be 2..32 and TIMEOUT at least 2");
  end

  logic [0:0]    state_reg, state_next;
  logic [NW-1:0] ptr_reg, ptr_next;
  logic [NW-1:0] grant_id_reg, grant_id_next;
  logic [N-1:0]  grants_reg, grants_next;
  logic          busy_reg, busy_next;

  // Doubling the request vector lets a plain shift by ptr give the rotated scan order.
  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [NW-1:0]  offset;
  logic [NW:0]    win_sum;
  logic [NW-1:0]  winner;
  logic [N-1:0]   win_onehot;

  assign req_dbl = {bus.requests, bus.requests};
  assign req_rot = req_dbl[ptr_reg +: N];

  always_comb begin
    offset = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = NW'(i);
    end
  end

  assign win_sum = {1'b0, ptr_reg} + {1'b0, offset};
  assign winner  = (win_sum >= N_EXT) ? NW'(win_sum - N_EXT) : win_sum[NW-1:0];

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign win_onehot[gi] = (winner == NW'(gi));
  end

  logic          xfer;
  logic          end_burst;
  logic          force_release;
  logic          release_now;
  logic [NW-1:0] ptr_after;

  assign xfer        = bus.requests[grant_id_reg] & bus.ready;
  assign end_burst   = xfer & bus.last[grant_id_reg];
  assign release_now = (state_reg == BUSY) & (end_burst | force_release);
  assign ptr_after   = (grant_id_reg == NW'(N - 1)) ? '0 : grant_id_reg + 1'b1;

`ifdef OH_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT);

  logic [SW-1:0] stall_reg, stall_next;
  logic          timeout_reg, timeout_next;

  assign force_release = (state_reg == BUSY) & ~xfer & (stall_reg == SW'(TIMEOUT - 1));

  always_comb begin
    stall_next   = stall_reg;
    timeout_next = force_release;
    if (state_reg != BUSY || release_now || xfer) begin
      stall_next = '0;
    end else begin
      stall_next = stall_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_reg   <= '0;
      timeout_reg <= 1'b0;
    end else begin
      stall_reg   <= stall_next;
      timeout_reg <= timeout_next;
    end
  end

  assign bus.timeout = timeout_reg;
`else
  assign force_release = 1'b0;
  assign bus.timeout   = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    grants_next   = grants_reg;
    grant_id_next = grant_id_reg;
    busy_next     = busy_reg;
    case (state_reg)
      IDLE: begin
        if (|bus.requests) begin
          state_next    = BUSY;
          grants_next   = win_onehot;
          grant_id_next = winner;
          busy_next     = 1'b1;
        end
      end
      BUSY: begin
        // Other requesters are never looked at here: the grant is sticky until release.
        if (release_now) begin
          state_next    = IDLE;
          grants_next   = '0;
          grant_id_next = '0;
          busy_next     = 1'b0;
          ptr_next      = ptr_after;
        end
      end
      default: begin
        state_next    = IDLE;
        grants_next   = '0;
        grant_id_next = '0;
        busy_next     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      grants_reg   <= '0;
      grant_id_reg <= '0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      grants_reg   <= grants_next;
      grant_id_reg <= grant_id_next;
      busy_reg     <= busy_next;
    end
  end

  assign bus.grants   = grants_reg;
  assign bus.grant_id = grant_id_reg;
  assign bus.busy     = busy_reg;

endmodule

// File: tb/tb_oh_arbiter_rr.sv
// Bench for oh_arbiter_rr: directed scenarios with literal expectations plus a
// per-cycle comparison against a requester-ownership model.
module tb_oh_arbiter_rr;
  localparam int N       = 4;
  localparam int NW      = 2;
  localparam int TIMEOUT = 16;
`ifdef OH_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  oh_arbiter_rr_if #(.N(N), .NW(NW)) bus ();

  oh_arbiter_rr #(.N(N), .NW(NW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: who owns the resource (-1 = nobody), where the scan starts, and stall cycles seen.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_stall = 0;
  bit m_to    = 1'b0;
  bit started = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_owner = -1;
      m_ptr   = 0;
      m_stall = 0;
      m_to    = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        m_stall = 0;
        for (int i = 0; i < N; i++) begin
          int c;
          c = (m_ptr + i) % N;
          if (m_owner < 0 && bus.requests[c]) m_owner = c;
        end
      end else begin
        bit moved;
        moved = bus.requests[m_owner] && bus.ready;
        if (moved && bus.last[m_owner]) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_stall = 0;
        end else if (moved) begin
          m_stall = 0;
        end else begin
          m_stall++;
          if (TO_EN && m_stall == TIMEOUT) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_stall = 0;
            m_to    = 1'b1;
          end
        end
      end
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_grants", 32'(bus.grants), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      chk("model_grant_id", 32'(bus.grant_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
      chk("model_busy", 32'(bus.busy), 32'(m_owner >= 0));
      chk("model_timeout", 32'(bus.timeout), 32'(m_to));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [3:0] g, input logic [1:0] id, input logic b);
    chk({name, "_grants"}, 32'(bus.grants), 32'(g));
    chk({name, "_id"}, 32'(bus.grant_id), 32'(id));
    chk({name, "_busy"}, 32'(bus.busy), 32'(b));
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic rd);
    bus.requests = r;
    bus.last     = l;
    bus.ready    = rd;
  endtask

  logic [5:0] ready_pat;

  initial begin
    reset = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0);
    cyc();
    cyc();
    expect_out("reset", 4'b0000, 2'd0, 1'b0);
    chk("reset_timeout", 32'(bus.timeout), 32'd0);
    reset = 1'b0;

    // Idle with no requests
    for (int k = 0; k < 10; k++) begin
      cyc();
      expect_out("idle", 4'b0000, 2'd0, 1'b0);
    end

    // Single-beat bursts from requesters 0 and 2 alternate with a bubble between
    drive(4'b0101, 4'b0101, 1'b1);
    cyc(); expect_out("sb1", 4'b0001, 2'd0, 1'b1);
    cyc(); expect_out("sb2", 4'b0000, 2'd0, 1'b0);
    cyc(); expect_out("sb3", 4'b0100, 2'd2, 1'b1);
    cyc(); expect_out("sb4", 4'b0000, 2'd0, 1'b0);
    cyc(); expect_out("sb5", 4'b0001, 2'd0, 1'b1);
    cyc(); expect_out("sb6", 4'b0000, 2'd0, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);
    cyc(); expect_out("sb7", 4'b0000, 2'd0, 1'b0);

    // Four-beat burst from requester 1 throttled by ready
    ready_pat = 6'b110101;
    drive(4'b0010, 4'b0000, 1'b0);
    cyc();
    for (int k = 0; k < 6; k++) begin
      expect_out("burst", 4'b0010, 2'd1, 1'b1);
      drive(4'b0010, (k == 5) ? 4'b0010 : 4'b0000, ready_pat[k]);
      cyc();
    end
    expect_out("burst_end", 4'b0000, 2'd0, 1'b0);
    drive(4'b1111, 4'b0000, 1'b0);
    cyc(); expect_out("ptr2", 4'b0100, 2'd2, 1'b1);
    drive(4'b1111, 4'b0100, 1'b1);
    cyc(); expect_out("rel2", 4'b0000, 2'd0, 1'b0);

    // Reset mid-burst: pointer was 3, must return to 0
    drive(4'b0010, 4'b0000, 1'b1);
    cyc(); expect_out("rst_g", 4'b0010, 2'd1, 1'b1);
    cyc(); expect_out("rst_beat", 4'b0010, 2'd1, 1'b1);
    reset = 1'b1;
    cyc(); expect_out("rst_mid", 4'b0000, 2'd0, 1'b0);
    reset = 1'b0;
    drive(4'b1111, 4'b0000, 1'b0);
    cyc(); expect_out("rst_first", 4'b0001, 2'd0, 1'b1);
    drive(4'b1111, 4'b0001, 1'b1);
    cyc(); expect_out("rst_rel", 4'b0000, 2'd0, 1'b0);

    // Sticky grant on requester 3 while its request drops; no preemption by 0
    drive(4'b1000, 4'b0000, 1'b1);
    cyc(); expect_out("sticky_g", 4'b1000, 2'd3, 1'b1);
    drive(4'b0001, 4'b0000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cyc(); expect_out("sticky", 4'b1000, 2'd3, 1'b1);
    end
    drive(4'b1001, 4'b1000, 1'b1);
    cyc(); expect_out("sticky_rel", 4'b0000, 2'd0, 1'b0);
    drive(4'b0001, 4'b0000, 1'b1);
    cyc(); expect_out("after_sticky", 4'b0001, 2'd0, 1'b1);
    drive(4'b0001, 4'b0001, 1'b1);
    cyc(); expect_out("after_rel", 4'b0000, 2'd0, 1'b0);

    // Stalled grant on requester 2
    drive(4'b0100, 4'b0000, 1'b0);
    cyc(); expect_out("stall_g", 4'b0100, 2'd2, 1'b1);
`ifdef OH_ARB_TIMEOUT_EN
    for (int k = 0; k < 15; k++) begin
      cyc(); expect_out("stall", 4'b0100, 2'd2, 1'b1);
      chk("stall_timeout", 32'(bus.timeout), 32'd0);
    end
    drive(4'b1111, 4'b0000, 1'b0);
    cyc(); expect_out("to_drop", 4'b0000, 2'd0, 1'b0);
    chk("to_pulse", 32'(bus.timeout), 32'd1);
    cyc(); expect_out("to_ptr3", 4'b1000, 2'd3, 1'b1);
    chk("to_pulse_end", 32'(bus.timeout), 32'd0);
`else
    for (int k = 0; k < 20; k++) begin
      cyc(); expect_out("stall", 4'b0100, 2'd2, 1'b1);
      chk("stall_timeout", 32'(bus.timeout), 32'd0);
    end
    drive(4'b0100, 4'b0100, 1'b1);
    cyc(); expect_out("stall_rel", 4'b0000, 2'd0, 1'b0);
    drive(4'b1111, 4'b0000, 1'b0);
    cyc(); expect_out("stall_ptr3", 4'b1000, 2'd3, 1'b1);
`endif
    drive(4'b1111, 4'b1000, 1'b1);
    cyc(); expect_out("final_rel", 4'b0000, 2'd0, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);
    cyc(); expect_out("final_idle", 4'b0000, 2'd0, 1'b0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/oh_arbiter_rr.md
Name: oh_arbiter_rr

Overview:
- Registered round-robin arbiter with burst locking. Shares one downstream resource (bus, FIFO write port, memory port) among N requesters.
- A requester that wins keeps the grant until it signals the end of its burst. The priority pointer then rotates past it.
- Sits in front of the shared resource. The downstream ready signal throttles transfers.

Parameters:
- N, 4, number of requesters (2..32)
- NW, $clog2(N), width of grant_id
- TIMEOUT, 16, stall-cycle limit before forced release (used only with OH_ARB_TIMEOUT_EN; minimum 2)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous reset, active-high
- requests  input  N  per-requester request level
- last  input  N  per-requester end-of-burst flag, qualified by transfer
- ready  input  1  downstream accepts a transfer this cycle
- grants  output  N  registered one-hot grant; all zero when idle
- grant_id  output  NW  binary index of the granted requester; 0 when idle
- busy  output  1  grant currently held
- timeout  output  1  one-cycle pulse on a forced release; constant 0 without the macro

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port name reset. All state changes on the rising edge of clk.
- Reset values:
  - grants=0, grant_id=0, busy=0, timeout=0
  - priority pointer ptr=0, state IDLE, stall counter=0
- State IDLE:
  - If requests==0, stay in IDLE.
  - Otherwise select the first set bit scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap-around).
  - Next cycle: grants=onehot(winner), grant_id=winner, busy=1, state BUSY.
  - Latency from request to grant is 1 cycle.
- State BUSY, granted index g:
  - transfer = requests[g] & ready.
  - transfer & last[g]: release. Next cycle grants=0, busy=0, ptr=(g+1) mod N (wraps N-1 to 0), state IDLE.
  - transfer & !last[g]: hold the grant.
  - requests[g] low without last: hold the grant (sticky). The grant is released only by last or by timeout.
  - Requests from other requesters never preempt.
- Release always passes through one IDLE cycle. Minimum grant-to-grant spacing is 2 cycles, so the bus shows one bubble cycle between bursts.
- ptr changes only on release; arbitration in IDLE leaves it unchanged.
- A single-beat burst (last high on the first transfer) is legal: grant lasts 1 cycle, then IDLE.
- Simultaneous requests in IDLE: pointer order decides. No requester waits more than N-1 bursts.
- last[] or requests[] of non-granted requesters are ignored in BUSY.
- Reset asserted mid-burst: grant drops next cycle, ptr returns to 0, no release side effects.
- grants and grant_id come directly from flops, with no combinational path from inputs.

Optional Feature:
- Macro: OH_ARB_TIMEOUT_EN.
- With the macro defined:
  - In BUSY, a stall counter increments each cycle with no transfer and clears on any transfer.
  - When the counter reaches TIMEOUT-1 on a no-transfer cycle, the arbiter forces a release.
  - Forced release: same effect as a normal release (ptr=(g+1) mod N, IDLE), and timeout pulses high for exactly the cycle grants drop to 0.
  - The counter clears on entry to IDLE and on reset. A transfer on the limit cycle takes priority (no timeout).
- Without the macro: no counter logic, timeout tied to 0, and a stalled grant is held indefinitely.

Test Plan:
- Reset, then requests=4'b0000 for 10 cycles -> grants=0, busy=0, grant_id=0 throughout.
- requests=4'b0101 from reset, ready=1, single-beat bursts (last=requests) -> grants sequence 0001, 0000, 0100, 0000, 0001, ...; grant_id 0, 2, 0.
- Requester 1 only, 4-beat burst, ready toggling 1,0,1,0,1,1 with last on the 4th transfer -> grants=0010 held for 6 cycles, then 0000; next arbitration starts at ptr=2.
- Grant held by requester 3, requests[3] dropped for 5 cycles with no last, requests[0] high -> grants stays 1000 (no preemption); release on last -> requester 0 granted 2 cycles after release.
- OH_ARB_TIMEOUT_EN, TIMEOUT=16: requester 2 granted, ready=0 for 20 cycles -> grants drops to 0 after 16 stall cycles, timeout pulses for 1 cycle, ptr=3.
- reset asserted while requester 1 mid-burst -> next cycle grants=0, busy=0; after reset release with requests=4'b1111, requester 0 is granted first.
